// File: rtl/cube_color_tracker_pkg.sv
// Shared types for the pyramid colour tracker and cube_generator.
// Holds FSM state type, colour-rule encodings and default geometry.
package cube_color_tracker_pkg;

  localparam int N_CUBE_DEFAULT = 28;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_TOGGLE = 2'd1;
  localparam logic [1:0] MODE_TWOHIT = 2'd2;

  localparam logic [1:0] DELTA_NONE = 2'b00;
  localparam logic [1:0] DELTA_INC  = 2'b01;
  localparam logic [1:0] DELTA_DEC  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    JUMP,
    FALL,
    CHECK,
    CLEARED
  } tracker_state_t;

endpackage

// File: rtl/cube_hit_rule.sv
// Colour rule for one landing: next done/half vectors and count delta.
// Purely combinational; target is assumed one-hot.
module cube_hit_rule
  import cube_color_tracker_pkg::*;
#(
  parameter int N_cube = N_CUBE_DEFAULT
) (
  input  logic [N_cube-1:0] done_v,
  input  logic [N_cube-1:0] half_v,
  input  logic [N_cube-1:0] target,
  input  logic [1:0]        mode,
  output logic [N_cube-1:0] pend_done,
  output logic [N_cube-1:0] pend_half,
  output logic [1:0]        delta
);

  logic hit_done;
  logic hit_half;
  logic rose;
  logic fell;

  assign hit_done = |(done_v & target);
  assign hit_half = |(half_v & target);

  always_comb begin
    pend_done = done_v;
    pend_half = half_v;
    unique case (1'b1)
      (mode == MODE_TOGGLE): begin
        pend_done = done_v ^ target;
        pend_half = '0;
      end
      (mode == MODE_TWOHIT): begin
        // a completed cube absorbs further hits unchanged
        if (!hit_done) begin
          if (hit_half) begin
            pend_done = done_v | target;
            pend_half = half_v & ~target;
          end else begin
            pend_half = half_v | target;
          end
        end
      end
      default: begin
        pend_done = done_v | target;
        pend_half = '0;
      end
    endcase
  end

  assign rose = |(target & ~done_v & pend_done);
  assign fell = |(target & done_v & ~pend_done);

  always_comb begin
    delta = DELTA_NONE;
    if (rose)
      delta = DELTA_INC;
    else if (fell)
      delta = DELTA_DEC;
  end

endmodule

// File: rtl/cube_color_tracker.sv
// Tracks visited-cube colours, lookahead to the landing cube,
// counts completed cubes and flags score, fall and level clear.
module cube_color_tracker
  import cube_color_tracker_pkg::*;
#(
  parameter int N_cube = N_CUBE_DEFAULT,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done_move,
  input  logic [N_cube-1:0] position_qb,
  input  logic [N_cube-1:0] e_next_qb,
  input  logic              level_start,
  input  logic [1:0]        mode,
  output logic [N_cube-1:0] e_color_state,
  output logic [N_cube-1:0] e_half_state,
  output logic [CNT_W-1:0]  cube_count,
  output logic              score_pulse,
  output logic              fall_pulse,
  output logic              level_done
);

  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_cube);

  tracker_state_t    state;
  logic [N_cube-1:0] done_reg;
  logic [N_cube-1:0] half_reg;
  logic [CNT_W-1:0]  count_reg;

  logic [N_cube-1:0] pend_done_q;
  logic [N_cube-1:0] pend_half_q;
  logic [CNT_W-1:0]  pend_count_q;
  logic              pend_rose_q;

  logic [N_cube-1:0] hit_done;
  logic [N_cube-1:0] hit_half;
  logic [1:0]        hit_delta;
  logic [CNT_W-1:0]  cnt_next;
  logic              moving;
  logic              off_pyr;
  logic              one_hot;

  cube_hit_rule #(
    .N_cube(N_cube)
  ) u_rule (
    .done_v   (done_reg),
    .half_v   (half_reg),
    .target   (e_next_qb),
    .mode     (mode),
    .pend_done(hit_done),
    .pend_half(hit_half),
    .delta    (hit_delta)
  );

  assign moving  = (e_next_qb != position_qb);
  assign off_pyr = (e_next_qb == '0);
  assign one_hot = $onehot(e_next_qb);

  // saturate at both ends of the cube range
  always_comb begin
    cnt_next = count_reg;
    if (hit_delta == DELTA_INC && count_reg < N_CNT)
      cnt_next = count_reg + 1'b1;
    else if (hit_delta == DELTA_DEC && count_reg != '0)
      cnt_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || level_start) begin
      state         <= IDLE;
      done_reg      <= '0;
      half_reg      <= '0;
      count_reg     <= '0;
      pend_done_q   <= '0;
      pend_half_q   <= '0;
      pend_count_q  <= '0;
      pend_rose_q   <= 1'b0;
      e_color_state <= '0;
      e_half_state  <= '0;
      cube_count    <= '0;
      score_pulse   <= 1'b0;
      fall_pulse    <= 1'b0;
      level_done    <= 1'b0;
    end else begin
      score_pulse <= 1'b0;
      fall_pulse  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (moving) begin
            if (off_pyr) begin
              state <= FALL;
            end else if (one_hot) begin
              pend_done_q   <= hit_done;
              pend_half_q   <= hit_half;
              pend_count_q  <= cnt_next;
              pend_rose_q   <= (hit_delta == DELTA_INC);
              e_color_state <= hit_done;
              e_half_state  <= hit_half;
              state         <= JUMP;
            end
          end
        end
        JUMP: begin
          if (done_move) begin
            done_reg    <= pend_done_q;
            half_reg    <= pend_half_q;
            count_reg   <= pend_count_q;
            cube_count  <= pend_count_q;
            score_pulse <= pend_rose_q;
            state       <= CHECK;
          end
        end
        FALL: begin
          if (done_move) begin
            fall_pulse <= 1'b1;
            state      <= IDLE;
          end
        end
        CHECK: begin
          if (count_reg == N_CNT) begin
            level_done <= 1'b1;
            state      <= CLEARED;
          end else begin
            state <= IDLE;
          end
        end
        CLEARED: begin
          level_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cube_color_tracker.sv
// Bench for cube_color_tracker: directed scenarios plus random jumps
// against a per-cube array model of the colour rules.
module tb_cube_color_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        done_move;
  logic [27:0] position_qb;
  logic [27:0] e_next_qb;
  logic        level_start;
  logic [1:0]  mode;
  logic [27:0] e_color_state;
  logic [27:0] e_half_state;
  logic [5:0]  cube_count;
  logic        score_pulse;
  logic        fall_pulse;
  logic        level_done;

  int vectors = 0;
  int miscompares = 0;

  bit [27:0] mdone;
  bit [27:0] mhalf;
  int        mcount;
  bit        mrose;

  cube_color_tracker #(.N_cube(28), .CNT_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .done_move    (done_move),
    .position_qb  (position_qb),
    .e_next_qb    (e_next_qb),
    .level_start  (level_start),
    .mode         (mode),
    .e_color_state(e_color_state),
    .e_half_state (e_half_state),
    .cube_count   (cube_count),
    .score_pulse  (score_pulse),
    .fall_pulse   (fall_pulse),
    .level_done   (level_done)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    mdone = '0;
    mhalf = '0;
    mcount = 0;
  endtask

  task automatic model_hit(input int k, input logic [1:0] m);
    int r;
    r = (m == 2'd3) ? 0 : int'(m);
    mrose = 1'b0;
    if (r == 0) begin
      mhalf = '0;
      if (!mdone[k]) begin mdone[k] = 1'b1; mrose = 1'b1; end
    end else if (r == 1) begin
      mhalf = '0;
      mdone[k] = !mdone[k];
      mrose = mdone[k];
    end else if (!mdone[k]) begin
      if (mhalf[k]) begin
        mhalf[k] = 1'b0; mdone[k] = 1'b1; mrose = 1'b1;
      end else begin
        mhalf[k] = 1'b1;
      end
    end
    mcount = $countones(mdone);
  endtask

  task automatic pulse_level_start();
    @(negedge clk);
    e_next_qb = position_qb;
    level_start = 1'b1;
    @(negedge clk);
    level_start = 1'b0;
    model_clear();
  endtask

  task automatic start_jump(input logic [27:0] dest);
    @(negedge clk);
    e_next_qb = dest;
    @(negedge clk);
  endtask

  task automatic finish_jump(input int wait_cycles);
    repeat (wait_cycles) @(negedge clk);
    done_move = 1'b1;
    @(negedge clk);
    done_move = 1'b0;
    if (e_next_qb != '0) position_qb = e_next_qb;
    else e_next_qb = position_qb;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    done_move = 1'b0;
    level_start = 1'b0;
    mode = 2'd0;
    position_qb = 28'h1;
    e_next_qb = 28'h1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({e_color_state, e_half_state} !== 56'h0) begin
      miscompares++;
      $display("FAIL reset_vec: got %h/%h want 0/0", e_color_state, e_half_state);
    end
    vectors++;
    if ({cube_count, score_pulse, fall_pulse, level_done} !== 9'h0) begin
      miscompares++;
      $display("FAIL reset_flags: got cnt=%0d s=%b f=%b l=%b want 0",
               cube_count, score_pulse, fall_pulse, level_done);
    end
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_single();
    mode = 2'd0;
    position_qb = 28'h1;
    pulse_level_start();
    start_jump(28'h2);
    vectors++;
    if (e_color_state !== 28'h2 || cube_count !== 6'd0) begin
      miscompares++;
      $display("FAIL single_lookahead: got %h cnt=%0d want 2 cnt=0", e_color_state, cube_count);
    end
    finish_jump(10);
    vectors++;
    if (cube_count !== 6'd1 || score_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL single_commit: got cnt=%0d s=%b want 1/1", cube_count, score_pulse);
    end
    @(negedge clk);
    vectors++;
    if (score_pulse !== 1'b0 || level_done !== 1'b0) begin
      miscompares++;
      $display("FAIL single_pulse_width: got s=%b l=%b want 0/0", score_pulse, level_done);
    end
  endtask

  task automatic test_toggle();
    mode = 2'd1;
    position_qb = 28'h1;
    pulse_level_start();
    start_jump(28'h2);
    finish_jump(2);
    vectors++;
    if (e_color_state !== 28'h2 || cube_count !== 6'd1 || score_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL toggle_first: got %h cnt=%0d s=%b want 2/1/1",
               e_color_state, cube_count, score_pulse);
    end
    start_jump(28'h4);
    finish_jump(2);
    start_jump(28'h2);
    vectors++;
    if (e_color_state !== 28'h4) begin
      miscompares++;
      $display("FAIL toggle_lookahead: got %h want 4", e_color_state);
    end
    finish_jump(3);
    vectors++;
    if (e_color_state[1] !== 1'b0 || cube_count !== 6'd1 || score_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL toggle_second: got bit1=%b cnt=%0d s=%b want 0/1/0",
               e_color_state[1], cube_count, score_pulse);
    end
  endtask

  task automatic test_twohit();
    mode = 2'd2;
    position_qb = 28'h1;
    pulse_level_start();
    start_jump(28'h8);
    finish_jump(2);
    vectors++;
    if (e_half_state !== 28'h8 || e_color_state !== 28'h0 || cube_count !== 6'd0) begin
      miscompares++;
      $display("FAIL twohit_first: got h=%h c=%h cnt=%0d want 8/0/0",
               e_half_state, e_color_state, cube_count);
    end
    start_jump(28'h10);
    finish_jump(2);
    start_jump(28'h8);
    finish_jump(2);
    vectors++;
    if (e_color_state !== 28'h8 || e_half_state !== 28'h10 ||
        cube_count !== 6'd1 || score_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL twohit_second: got c=%h h=%h cnt=%0d s=%b want 8/10/1/1",
               e_color_state, e_half_state, cube_count, score_pulse);
    end
  endtask

  task automatic test_fall();
    start_jump(28'h0);
    vectors++;
    if (e_color_state !== 28'h8) begin
      miscompares++;
      $display("FAIL fall_hold: got %h want 8", e_color_state);
    end
    finish_jump(3);
    vectors++;
    if (fall_pulse !== 1'b1 || score_pulse !== 1'b0 ||
        e_color_state !== 28'h8 || cube_count !== 6'd1) begin
      miscompares++;
      $display("FAIL fall_pulse: got f=%b s=%b c=%h cnt=%0d want 1/0/8/1",
               fall_pulse, score_pulse, e_color_state, cube_count);
    end
    @(negedge clk);
    vectors++;
    if (fall_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL fall_width: got %b want 0", fall_pulse);
    end
    done_move = 1'b1;
    @(negedge clk);
    done_move = 1'b0;
    @(negedge clk);
    vectors++;
    if (fall_pulse !== 1'b0 || score_pulse !== 1'b0 ||
        e_color_state !== 28'h8 || cube_count !== 6'd1) begin
      miscompares++;
      $display("FAIL idle_done_move: got f=%b s=%b c=%h cnt=%0d want 0/0/8/1",
               fall_pulse, score_pulse, e_color_state, cube_count);
    end
  endtask

  task automatic test_level_clear();
    logic [27:0] dest;
    mode = 2'd0;
    position_qb = 28'h1;
    pulse_level_start();
    for (int i = 1; i <= 28; i++) begin
      dest = 28'h1 << (i % 28);
      start_jump(dest);
      finish_jump(1);
      vectors++;
      if (cube_count !== 6'(i) || score_pulse !== 1'b1 || level_done !== 1'b0) begin
        miscompares++;
        $display("FAIL level_visit%0d: got cnt=%0d s=%b l=%b want %0d/1/0",
                 i, cube_count, score_pulse, level_done, i);
      end
    end
    @(negedge clk);
    vectors++;
    if (level_done !== 1'b1) begin
      miscompares++;
      $display("FAIL level_done_rise: got %b want 1", level_done);
    end
    mode = 2'd1;
    start_jump(28'h20);
    finish_jump(3);
    @(negedge clk);
    vectors++;
    if (level_done !== 1'b1 || e_color_state !== 28'hFFFFFFF ||
        cube_count !== 6'd28 || score_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL cleared_ignore: got l=%b c=%h cnt=%0d s=%b want 1/fffffff/28/0",
               level_done, e_color_state, cube_count, score_pulse);
    end
    pulse_level_start();
    vectors++;
    if (level_done !== 1'b0 || e_color_state !== 28'h0 ||
        e_half_state !== 28'h0 || cube_count !== 6'd0) begin
      miscompares++;
      $display("FAIL level_restart: got l=%b c=%h h=%h cnt=%0d want 0",
               level_done, e_color_state, e_half_state, cube_count);
    end
  endtask

  task automatic test_abort_multihot();
    mode = 2'd0;
    position_qb = 28'h1;
    pulse_level_start();
    start_jump(28'h20);
    vectors++;
    if (e_color_state !== 28'h20) begin
      miscompares++;
      $display("FAIL abort_lookahead: got %h want 20", e_color_state);
    end
    level_start = 1'b1;
    done_move = 1'b1;
    e_next_qb = position_qb;
    @(negedge clk);
    level_start = 1'b0;
    done_move = 1'b0;
    model_clear();
    vectors++;
    if (e_color_state !== 28'h0 || cube_count !== 6'd0 || score_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_discard: got c=%h cnt=%0d s=%b want 0/0/0",
               e_color_state, cube_count, score_pulse);
    end
    e_next_qb = 28'h3;
    repeat (3) @(negedge clk);
    done_move = 1'b1;
    @(negedge clk);
    done_move = 1'b0;
    vectors++;
    if (e_color_state !== 28'h0 || score_pulse !== 1'b0 || cube_count !== 6'd0) begin
      miscompares++;
      $display("FAIL multihot_ignore: got c=%h s=%b cnt=%0d want 0/0/0",
               e_color_state, score_pulse, cube_count);
    end
    start_jump(28'h4);
    vectors++;
    if (e_color_state !== 28'h4) begin
      miscompares++;
      $display("FAIL multihot_idle: got %h want 4", e_color_state);
    end
    finish_jump(1);
    @(negedge clk);
  endtask

  task automatic test_random();
    int cur;
    int k;
    logic [1:0] m;
    position_qb = 28'h1;
    cur = 0;
    pulse_level_start();
    for (int n = 0; n < 60; n++) begin
      m = 2'($urandom_range(0, 3));
      mode = m;
      if ($urandom_range(0, 7) == 0) begin
        start_jump(28'h0);
        finish_jump($urandom_range(1, 4));
        vectors++;
        if (fall_pulse !== 1'b1 || e_color_state !== mdone || cube_count !== 6'(mcount)) begin
          miscompares++;
          $display("FAIL rand_fall%0d: got f=%b c=%h cnt=%0d want 1/%h/%0d",
                   n, fall_pulse, e_color_state, cube_count, mdone, mcount);
        end
      end else begin
        k = $urandom_range(0, 27);
        if (k == cur) k = (k + 1) % 28;
        model_hit(k, m);
        start_jump(28'h1 << k);
        vectors++;
        if (e_color_state !== mdone || e_half_state !== mhalf) begin
          miscompares++;
          $display("FAIL rand_look%0d: got c=%h h=%h want %h/%h",
                   n, e_color_state, e_half_state, mdone, mhalf);
        end
        finish_jump($urandom_range(1, 4));
        cur = k;
        vectors++;
        if (cube_count !== 6'(mcount) || score_pulse !== mrose) begin
          miscompares++;
          $display("FAIL rand_land%0d: got cnt=%0d s=%b want %0d/%b",
                   n, cube_count, score_pulse, mcount, mrose);
        end
        @(negedge clk);
        vectors++;
        if (level_done !== (mcount == 28)) begin
          miscompares++;
          $display("FAIL rand_level%0d: got %b want %b", n, level_done, mcount == 28);
        end
        if (mcount == 28) pulse_level_start();
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_toggle();
    test_twohit();
    test_fall();
    test_level_clear();
    test_abort_multihot();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
